// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clk; done pulses WIDTH+1 cycles after an accepted start.
// No backpressure: start is taken only in IDLE or DONE and ignored while busy; results hold until the next completion.
module serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_out_q, borrow_out_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;

   logic             ai, bi, di, br_nx;
   logic [WIDTH-1:0] res_nx;

   always_comb begin
      state_d      = state_q;
      a_sr_d       = a_sr_q;
      b_sr_d       = b_sr_q;
      res_sr_d     = res_sr_q;
      cnt_d        = cnt_q;
      br_d         = br_q;
      a_msb_d      = a_msb_q;
      b_msb_d      = b_msb_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      overflow_d   = overflow_q;
      zero_d       = zero_q;

      ai     = a_sr_q[0];
      bi     = b_sr_q[0];
      di     = ai ^ bi ^ br_q;
      br_nx  = (~ai & bi) | (~(ai ^ bi) & br_q);
      res_nx = {di, res_sr_q[WIDTH-1:1]};

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_SHIFT;
               a_sr_d  = a;
               b_sr_d  = b;
               br_d    = borrow_in;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
            end
         end
         S_SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = res_nx;
            br_d     = br_nx;
            cnt_d    = cnt_q + CW'(1);
            // Final bit: publish the whole result at once so diff never shows partial bits.
            if (cnt_q == LAST) begin
               state_d      = S_DONE;
               diff_d       = res_nx;
               borrow_out_d = br_nx;
               overflow_d   = (a_msb_q != b_msb_q) && (res_nx[WIDTH-1] != a_msb_q);
               zero_d       = ~|res_nx;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         a_sr_q       <= '0;
         b_sr_q       <= '0;
         res_sr_q     <= '0;
         cnt_q        <= '0;
         br_q         <= 1'b0;
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sr_q       <= a_sr_d;
         b_sr_q       <= b_sr_d;
         res_sr_q     <= res_sr_d;
         cnt_q        <= cnt_d;
         br_q         <= br_d;
         a_msb_q      <= a_msb_d;
         b_msb_q      <= b_msb_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         overflow_q   <= overflow_d;
         zero_q       <= zero_d;
      end
   end

   assign busy       = (state_q == S_SHIFT);
   assign done       = (state_q == S_DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign overflow   = overflow_q;
   assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against a plain-arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         borrow_in;
   logic         busy, done;
   logic [W-1:0] diff;
   logic         borrow_out, overflow, zero;

   int errors = 0;
   int checks = 0;

   // Result registers as they should currently read.
   logic [W-1:0] prev_diff = '0;
   logic         prev_bo = 1'b0, prev_ovf = 1'b0, prev_zero = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
      .overflow(overflow), .zero(zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                        output logic [W-1:0] d, output logic bo, output logic ovf, output logic z);
      logic [W:0] full;
      longint     sres;
      full = {1'b0, av} - {1'b0, bv} - (W+1)'(bin);
      d    = full[W-1:0];
      bo   = full[W];
      sres = longint'($signed(av)) - longint'($signed(bv)) - longint'(bin);
      ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      z    = (d == '0);
   endtask

   // Called at a negedge; returns at the negedge of the done cycle with start low.
   task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                      input bit hold, input string tag);
      logic [W-1:0] ed;
      logic         ebo, eovf, ez;
      int           busy_n;
      bit           early_done, stable;
      model(av, bv, bin, ed, ebo, eovf, ez);
      a = av; b = bv; borrow_in = bin; start = 1'b1;
      busy_n = 0; early_done = 0; stable = 1;
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         if (hold) begin
            a = '0; b = '0; borrow_in = 1'b0;
         end else begin
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
         end
         busy_n += int'(busy);
         early_done |= (done === 1'b1);
         stable &= (diff === prev_diff) && (borrow_out === prev_bo) &&
                   (overflow === prev_ovf) && (zero === prev_zero);
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, "/busy_cycles"}, 64'(busy_n), 64'(W));
      chk({tag, "/no_early_done"}, 64'(early_done), 64'd0);
      chk({tag, "/held_during_shift"}, 64'(stable), 64'd1);
      chk({tag, "/done"}, {62'd0, done, busy}, {62'd0, 2'b10});
      chk({tag, "/diff"}, 64'(diff), 64'(ed));
      chk({tag, "/flags"}, {61'd0, borrow_out, overflow, zero}, {61'd0, ebo, eovf, ez});
      prev_diff = ed; prev_bo = ebo; prev_ovf = eovf; prev_zero = ez;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           dn;
      rst_n = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset/outputs", {29'd0, busy, done, borrow_out, overflow, zero, diff},
          {29'd0, 5'b00000, 32'd0});
      rst_n = 1'b1;
      @(negedge clk);

      run(32'd5, 32'd3, 1'b0, 0, "t1");
      @(negedge clk);
      chk("t1/idle_hold", {31'd0, done, diff}, {31'd0, 1'b0, 32'd2});

      @(negedge clk);
      run(32'd3, 32'd5, 1'b0, 0, "t2");
      chk("t2/diff_const", 64'(diff), 64'hFFFF_FFFE);

      @(negedge clk);
      run(32'h8000_0000, 32'd1, 1'b0, 0, "t3a");
      chk("t3a/ovf_const", {62'd0, overflow, borrow_out}, {62'd0, 2'b10});
      @(negedge clk);
      run(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "t3b");
      chk("t3b/ovf_const", {62'd0, overflow, borrow_out}, {62'd0, 2'b11});

      @(negedge clk);
      run(32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 0, "t4a");
      chk("t4a/zero_const", 64'(zero), 64'd1);
      @(negedge clk);
      run(32'h1234_ABCD, 32'h1234_ABCD, 1'b1, 0, "t4b");
      chk("t4b/diff_const", {31'd0, zero, diff}, {31'd0, 1'b0, 32'hFFFF_FFFF});

      // Start held high through SHIFT, then a back-to-back start in the DONE cycle.
      @(negedge clk);
      run(32'd10, 32'd4, 1'b0, 1, "t5a");
      chk("t5a/diff_const", 64'(diff), 64'd6);
      run(32'd9, 32'd9, 1'b0, 0, "t5b");
      chk("t5b/zero_const", 64'(zero), 64'd1);

      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         run(ra, rb, 1'($urandom), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      end

      @(negedge clk);
      run(32'd1, 32'd2, 1'b0, 0, "t6pre");

      // Async reset mid-operation.
      @(negedge clk);
      a = 32'd100; b = 32'd1; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("t6/busy_before_reset", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6/reset_outputs", {29'd0, busy, done, borrow_out, overflow, zero, diff},
          {29'd0, 5'b00000, 32'd0});
      prev_diff = '0; prev_bo = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
      dn = 0;
      repeat (3) begin
         @(negedge clk);
         dn += int'(done);
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         dn += int'(done);
      end
      chk("t6/no_done_after_abort", 64'(dn), 64'd0);
      run(32'd7, 32'd8, 1'b0, 0, "t6post");
      chk("t6post/const", {31'd0, borrow_out, diff}, {31'd0, 1'b1, 32'hFFFF_FFFF});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
